spi_periph_bridge: RTL and testbench
====================================

Name: spi_periph_bridge

Overview:
- SPI mode-0 slave that turns host SPI transactions into single-cycle register accesses on the TinyQV peripheral bus (address, write data, write strobe, read data).
- Sits directly upstream of the peripheral under test in the test harness. Receives the already-synchronised SPI pins. Drives address, data_in and data_write to the peripheral, and returns its data_out on MISO.
- Supports burst transfers with address auto-increment.

Parameters:
- ADDR_W, 4, width of the register address; taken from the command byte bits [ADDR_W-1:0], max 7.
- DATA_W, 8, register data width; fixed at 8, any other value is unsupported.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- spi_cs_n  input  1  chip select, active-low, already synchronised to clk
- spi_clk  input  1  SPI clock, already synchronised; idle low
- spi_mosi  input  1  host-to-slave data, already synchronised
- spi_miso  output  1  slave-to-host data
- reg_addr  output  ADDR_W  register address to the peripheral
- reg_data_i  input  8  read data from the peripheral, combinational on reg_addr
- reg_data_o  output  8  write data to the peripheral
- reg_data_o_dv  output  1  write strobe, one clk cycle

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: reg_addr=0, reg_data_o=0, reg_data_o_dv=0, spi_miso=0, state=IDLE, bit_cnt=0, shift registers=0. Reset takes priority over all other events, including mid-transfer.
- Edge detection: sclk_q holds the previous spi_clk value.
  - rise = spi_clk & ~sclk_q.
  - fall = ~spi_clk & sclk_q.
  - The host must hold each SPI clock phase for at least 4 clk cycles.
- Framing: the first byte is the command, sent MSB first.
  - bit7 = 1 means write, 0 means read.
  - bits[6:ADDR_W] are ignored.
  - bits[ADDR_W-1:0] are the start address.
  - Every following byte is a data byte.
- States:
  - IDLE: spi_cs_n=1. bit_cnt=0, MISO=0. Move to CMD when spi_cs_n=0.
  - CMD: on each rise, shift MOSI into shift_in and increment bit_cnt. On the 8th rise:
    - latch reg_addr = shift_in[ADDR_W-1:0] and the rw flag;
    - bit_cnt wraps to 0;
    - go to DATA.
  - DATA, write (rw=1): on each rise, shift MOSI in. On the 8th rise:
    - reg_data_o gets the full byte in that same cycle's update;
    - reg_data_o_dv=1 for exactly the next cycle, with reg_addr still at the current address;
    - in the cycle after the strobe, reg_addr increments modulo 2^ADDR_W.
  - DATA, read (rw=0): handled by the MISO rules below.
  - Any state: spi_cs_n=1 forces IDLE on the next cycle. A partial byte is discarded, no strobe is issued, and reg_addr keeps its last value.
- MISO, read transactions:
  - One cycle after reg_addr is updated (end of the command byte, or after each increment), shift_out loads reg_data_i.
  - spi_miso = shift_out[7].
  - On each fall with bit_cnt != 0, shift_out shifts left.
  - The fall immediately after an 8th rise (bit_cnt=0) does not shift.
  - On the 8th rise of each read data byte, reg_addr increments modulo 2^ADDR_W and shift_out reloads one cycle later.
- MISO is 0 during CMD, during write transactions, and in IDLE.
- Address wrap: 2^ADDR_W-1 increments to 0 with no error indication.
- spi_cs_n rising on the same cycle as an 8th rise: the byte is lost and no strobe is issued. CS deassertion wins.
- Latency: write strobe appears 1 clk after the detected 8th rise. First MISO bit is valid 2 clk after the 8th command rise.

Test Plan:
- Write single: CS low, send 0x83 then 0x5A, CS high -> exactly one reg_data_o_dv pulse with reg_addr=3 and reg_data_o=0x5A; reg_addr=4 afterwards.
- Read single: peripheral returns 0xA5 at addr 2; send 0x02 then 8 dummy clocks -> host samples 0xA5 on MISO, MSB first on rising edges; reg_data_o_dv never asserts.
- Burst write with wrap: send 0x8E then 0x11, 0x22, 0x33 -> strobes at addr E=0x11, F=0x22, 0=0x33.
- Burst read: addr 5=0x10, addr 6=0x20; send 0x05 then 16 dummy clocks -> host receives 0x10 then 0x20.
- CS abort: send 0x81, then 5 bits of a data byte, then CS high -> no strobe; the next transaction 0x81, 0x7F -> single strobe with addr 1 and data 0x7F.
- Reset mid-transfer: assert rst for 1 cycle during bit 4 of a data byte -> all outputs 0 the next cycle; the following full transaction behaves normally.

Source files
------------

// File: rtl/spi_periph_bridge.sv
// SPI mode-0 slave that bridges host transactions onto a single-cycle register bus.
// The first byte is the command (bit7 = write); every following byte is data, with address auto-increment.
module spi_periph_bridge #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_data_o_dv
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t              state_q;
  logic                sclk_q;
  logic [2:0]          bit_cnt_q;
  logic [DATA_W-1:0]   shift_in_q, shift_out_q, data_o_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q, dv_q, inc_q, load_q;
  logic                rise, fall;
  logic [DATA_W-1:0]   nxt_byte;

  assign rise     = spi_clk & ~sclk_q;
  assign fall     = ~spi_clk & sclk_q;
  assign nxt_byte = {shift_in_q[DATA_W-2:0], spi_mosi};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      data_o_q    <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      dv_q        <= 1'b0;
      inc_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      sclk_q <= spi_clk;
      dv_q   <= 1'b0;
      inc_q  <= 1'b0;
      load_q <= 1'b0;
      // Post-strobe increment and read reload run one cycle behind their trigger,
      // so the peripheral sees a stable address for the strobe / combinational read.
      if (inc_q)  addr_q      <= addr_q + 1'b1;
      if (load_q) shift_out_q <= reg_data_i;
      if (spi_cs_n) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
          end
          CMD: if (rise) begin
            shift_in_q <= nxt_byte;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_q  <= nxt_byte[ADDR_W-1:0];
              rw_q    <= nxt_byte[7];
              load_q  <= ~nxt_byte[7];
              state_q <= DATA;
            end
          end
          DATA: begin
            if (rise) begin
              shift_in_q <= nxt_byte;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rw_q) begin
                  data_o_q <= nxt_byte;
                  dv_q     <= 1'b1;
                  inc_q    <= 1'b1;
                end else begin
                  addr_q <= addr_q + 1'b1;
                  load_q <= 1'b1;
                end
              end
            end
            // The fall right after a byte boundary keeps the freshly reloaded MSB.
            if (fall && bit_cnt_q != 3'd0 && !rw_q)
              shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso      = (state_q == DATA && !rw_q) ? shift_out_q[DATA_W-1] : 1'b0;
  assign reg_addr      = addr_q;
  assign reg_data_o    = data_o_q;
  assign reg_data_o_dv = dv_q;

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Bench for spi_periph_bridge: table of SPI transactions plus abort / reset sequences,
// with write strobes and read bytes checked against scoreboard queues.
module tb_spi_periph_bridge;

  localparam int HALF = 5;

  logic       clk, rst, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [3:0] reg_addr;
  logic [7:0] reg_data_i, reg_data_o;
  logic       reg_data_o_dv;
  logic [7:0] mem [16];

  int tests = 0;
  int fails = 0;
  logic [11:0] wq[$];
  logic [7:0]  rq[$];

  spi_periph_bridge #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .reg_addr(reg_addr), .reg_data_i(reg_data_i),
    .reg_data_o(reg_data_o), .reg_data_o_dv(reg_data_o_dv)
  );

  assign reg_data_i = mem[reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && reg_data_o_dv) begin
      if (wq.size() == 0) check("unexpected_strobe", {reg_addr, reg_data_o}, 12'h000);
      else check("strobe_addr_data", {reg_addr, reg_data_o}, wq.pop_front());
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0, MSB first; MISO is sampled at each rising SPI edge.
  task automatic send_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      rx[i]   = spi_miso;
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]      cmd;
    int              n;
    logic [3:0][7:0] d;          // write data, or expected read bytes
    logic [3:0]      addr_after;
  } vec_t;

  task automatic run_txn(input logic [7:0] cmd, input int n, input logic [3:0][7:0] d,
                         input logic [3:0] addr_after);
    logic [7:0] rx;
    logic [3:0] a;
    a = cmd[3:0];
    spi_cs_n = 1'b0;
    wait_clk(4);
    send_bits(cmd, 8, rx);
    check("miso_during_cmd", rx, 8'h00);
    for (int k = 0; k < n; k++) begin
      if (cmd[7]) begin
        wq.push_back({a, d[k]});
        send_bits(d[k], 8, rx);
        check("miso_during_write", rx, 8'h00);
      end else begin
        rq.push_back(d[k]);
        send_bits(8'h00, 8, rx);
        check("read_byte", rx, rq.pop_front());
      end
      a = a + 4'd1;
    end
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
    check("missing_strobes", wq.size(), 0);
    check("addr_after", reg_addr, addr_after);
    check("miso_idle", spi_miso, 1'b0);
  endtask

  vec_t vecs [5];
  logic [7:0] junk;

  initial begin
    vecs[0] = '{cmd: 8'h83, n: 1, d: {8'h00, 8'h00, 8'h00, 8'h5A}, addr_after: 4'h4};
    vecs[1] = '{cmd: 8'h02, n: 1, d: {8'h00, 8'h00, 8'h00, 8'hA5}, addr_after: 4'h3};
    vecs[2] = '{cmd: 8'h8E, n: 3, d: {8'h00, 8'h33, 8'h22, 8'h11}, addr_after: 4'h1};
    vecs[3] = '{cmd: 8'h05, n: 2, d: {8'h00, 8'h00, 8'h20, 8'h10}, addr_after: 4'h7};
    vecs[4] = '{cmd: 8'h0F, n: 2, d: {8'h00, 8'h00, 8'h3E, 8'h5C}, addr_after: 4'h1};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[2] = 8'hA5; mem[5] = 8'h10; mem[6] = 8'h20; mem[15] = 8'h5C; mem[0] = 8'h3E;

    rst = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    check("rst_addr", reg_addr, 4'h0);
    check("rst_data_o", reg_data_o, 8'h00);
    check("rst_dv", reg_data_o_dv, 1'b0);
    check("rst_miso", spi_miso, 1'b0);

    foreach (vecs[i]) run_txn(vecs[i].cmd, vecs[i].n, vecs[i].d, vecs[i].addr_after);

    // CS abort mid data byte: no strobe, address holds the command value.
    spi_cs_n = 1'b0;
    wait_clk(4);
    send_bits(8'h81, 8, junk);
    send_bits(8'hFF, 5, junk);
    spi_cs_n = 1'b1;
    wait_clk(10);
    check("abort_no_strobe", wq.size(), 0);
    check("abort_addr_kept", reg_addr, 4'h1);
    run_txn(8'h81, 1, {8'h00, 8'h00, 8'h00, 8'h7F}, 4'h2);

    // Reset during bit 4 of a data byte.
    spi_cs_n = 1'b0;
    wait_clk(4);
    send_bits(8'h83, 8, junk);
    send_bits(8'hF0, 3, junk);
    spi_mosi = 1'b1;
    wait_clk(2);
    spi_clk = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("midrst_addr", reg_addr, 4'h0);
    check("midrst_data_o", reg_data_o, 8'h00);
    check("midrst_dv", reg_data_o_dv, 1'b0);
    check("midrst_miso", spi_miso, 1'b0);
    spi_clk = 1'b0;
    spi_cs_n = 1'b1;
    wait_clk(8);
    run_txn(8'h84, 1, {8'h00, 8'h00, 8'h00, 8'hC3}, 4'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
